// File: rtl/icache_refill_engine.sv
// icache_refill_engine: fetches one instruction-cache block from main memory,
// one 32-bit word at a time, and presents the assembled block for a one-cycle
// cache write.
//
// Ports:
//   CLK, RESET               clock, synchronous active-low reset
//   Miss_Req, Miss_Addr      miss request (level) and missing byte address
//   Abort                    pipeline redirect, drops an in-flight fetch
//   MM_Req, MM_Addr          word read request / word-aligned address
//   MM_Ready, MM_Data        memory returns a word this cycle
//   Refill_Valid             one-cycle pulse qualifying Refill_Addr/Refill_Data
//   Refill_Addr, Refill_Data block-aligned address and assembled block
//   Busy                     engine is not idle
//   CNT_REFILL, CNT_ABORT    saturating completed / aborted refill counters
module icache_refill_engine #(
  parameter int unsigned WORDS  = 2,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                Miss_Req,
  input  logic [ADDR_W-1:0]   Miss_Addr,
  input  logic                Abort,
  output logic                MM_Req,
  output logic [ADDR_W-1:0]   MM_Addr,
  input  logic                MM_Ready,
  input  logic [31:0]         MM_Data,
  output logic                Refill_Valid,
  output logic [ADDR_W-1:0]   Refill_Addr,
  output logic [32*WORDS-1:0] Refill_Data,
  output logic                Busy,
  output logic [19:0]         CNT_REFILL,
  output logic [19:0]         CNT_ABORT
);

  localparam int unsigned IDX_W = $clog2(WORDS);
  localparam int unsigned OFS_W = IDX_W + 2;
  localparam int unsigned BLK_W = 32 * WORDS;
  localparam int unsigned CNT_W = 20;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [BLK_W-1:0]    line_q, line_d;

  logic                mm_req_d;
  logic [ADDR_W-1:0]   mm_addr_d;
  logic                refill_valid_d;
  logic [ADDR_W-1:0]   refill_addr_d;
  logic [BLK_W-1:0]    refill_data_d;
  logic                busy_d;
  logic [CNT_W-1:0]    cnt_refill_d, cnt_abort_d;

  // Offset bits inside the block are discarded when the base is latched.
  logic unused_offset;
  assign unused_offset = ^Miss_Addr[OFS_W-1:0];

  // Next-state, datapath and registered-output next values.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    base_d         = base_q;
    line_d         = line_q;
    mm_req_d       = 1'b0;
    mm_addr_d      = MM_Addr;
    refill_valid_d = 1'b0;
    refill_addr_d  = Refill_Addr;
    refill_data_d  = Refill_Data;
    busy_d         = 1'b0;
    cnt_refill_d   = CNT_REFILL;
    cnt_abort_d    = CNT_ABORT;

    unique case (state_q)
      IDLE: begin
        // Abort in IDLE suppresses the start even with a pending miss.
        if (Miss_Req && !Abort) begin
          state_d = FETCH;
          base_d  = {Miss_Addr[ADDR_W-1:OFS_W], OFS_W'(0)};
          idx_d   = '0;
        end
      end
      FETCH: begin
        // Abort wins over a simultaneous MM_Ready; the partial block is dropped.
        if (Abort) begin
          state_d = IDLE;
          if (CNT_ABORT != '1) cnt_abort_d = CNT_ABORT + CNT_W'(1);
        end else if (MM_Ready) begin
          line_d[32*int'(idx_q) +: 32] = MM_Data;
          if (idx_q == IDX_W'(WORDS - 1)) state_d = DONE;
          else                             idx_d   = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        // Abort is ignored here: the block is already complete.
        state_d = IDLE;
        if (CNT_REFILL != '1) cnt_refill_d = CNT_REFILL + CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase

    busy_d   = (state_d != IDLE);
    mm_req_d = (state_d == FETCH);
    // Index is OR-ed into the cleared offset field, so no carry into the base.
    if (state_d == FETCH) mm_addr_d = base_d | (ADDR_W'(idx_d) << 2);
    if (state_d == DONE) begin
      refill_valid_d = 1'b1;
      refill_addr_d  = base_d;
      refill_data_d  = line_d;
    end
  end

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      base_q       <= '0;
      line_q       <= '0;
      MM_Req       <= 1'b0;
      MM_Addr      <= '0;
      Refill_Valid <= 1'b0;
      Refill_Addr  <= '0;
      Refill_Data  <= '0;
      Busy         <= 1'b0;
      CNT_REFILL   <= '0;
      CNT_ABORT    <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      base_q       <= base_d;
      line_q       <= line_d;
      MM_Req       <= mm_req_d;
      MM_Addr      <= mm_addr_d;
      Refill_Valid <= refill_valid_d;
      Refill_Addr  <= refill_addr_d;
      Refill_Data  <= refill_data_d;
      Busy         <= busy_d;
      CNT_REFILL   <= cnt_refill_d;
      CNT_ABORT    <= cnt_abort_d;
    end
  end

endmodule

// File: doc/icache_refill_engine.md
ICACHE_REFILL_ENGINE -- requirements
Module: icache_refill_engine

Interface
REQ-001 Parameter WORDS, default 2: words per cache block; legal values 2 and 4.
REQ-002 Parameter ADDR_W, default 32: byte-address width.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RESET  input  1  synchronous, active-low reset; sampled on rising CLK.
REQ-005 Miss_Req  input  1  cache reports a miss on Miss_Addr; level, held until Refill_Valid.
REQ-006 Miss_Addr  input  ADDR_W  byte address of missing instruction (PC).
REQ-007 Abort  input  1  pipeline redirect; discard any in-flight refill.
REQ-008 MM_Req  output  1  main-memory word-read request.
REQ-009 MM_Addr  output  ADDR_W  word-aligned read address, low 2 bits = 0.
REQ-010 MM_Ready  input  1  main memory returns MM_Data this cycle.
REQ-011 MM_Data  input  32  returned word.
REQ-012 Refill_Valid  output  1  one-cycle pulse: Refill_Data/Refill_Addr valid for cache write.
REQ-013 Refill_Addr  output  ADDR_W  block-aligned address of returned block.
REQ-014 Refill_Data  output  32*WORDS  block; word i at bits [32i+31:32i].
REQ-015 Busy  output  1  high in any state other than IDLE.
REQ-016 CNT_REFILL  output  20  completed refills, saturating.
REQ-017 CNT_ABORT  output  20  aborted refills, saturating.

Function
REQ-018 FSM states SHALL be IDLE, FETCH, DONE.
REQ-019 IDLE->FETCH when Miss_Req=1 and Abort=0; latch block base = Miss_Addr with low log2(WORDS)+2 bits cleared; word index := 0.
REQ-020 In FETCH, MM_Req=1 and MM_Addr = base + 4*index; both held stable until MM_Ready=1.
REQ-021 On MM_Ready=1 in FETCH: capture MM_Data into word slot index; if index=WORDS-1 go DONE, else index+1, stay FETCH (MM_Req stays high next cycle, new address).
REQ-022 MM_Ready outside FETCH, or while Abort=1, SHALL be ignored.
REQ-023 DONE lasts exactly one cycle: Refill_Valid=1, Refill_Addr=base, Refill_Data=assembled block, CNT_REFILL+1; then IDLE.
REQ-024 Miss-to-Refill_Valid latency with MM_Ready high every cycle: WORDS+1 cycles after the IDLE->FETCH edge (IDLE samples miss at edge n; Refill_Valid high during cycle n+WORDS+1).
REQ-025 Abort=1 in FETCH: next state IDLE, no Refill_Valid, no data written, CNT_ABORT+1; MM_Req deasserts next cycle.
REQ-026 Abort=1 in DONE: ignored; block completes (already consistent data).
REQ-027 Abort=1 in IDLE: no transition that cycle even if Miss_Req=1; counters unchanged.
REQ-028 Back-to-back: Miss_Req still high in cycle after DONE SHALL start a new refill from IDLE (one IDLE cycle minimum between refills).
REQ-029 Miss_Addr changes during FETCH SHALL not affect MM_Addr or Refill_Addr.
REQ-030 Counters saturate at 20'hFFFFF; no wrap.
REQ-031 Outside DONE, Refill_Valid=0; Refill_Data/Refill_Addr hold last values.
REQ-032 Index counter width = log2(WORDS); MM_Addr computed without carry into bits above block base.

Reset
REQ-033 RESET=0 at a rising edge: state IDLE, index 0, base 0, MM_Req 0, MM_Addr 0, Refill_Valid 0, Refill_Addr 0, Refill_Data 0, Busy 0, CNT_REFILL 0, CNT_ABORT 0.
REQ-034 Reset mid-FETCH SHALL drop the transaction with no Refill_Valid and no counter update; reset has priority over all inputs.

Verification
REQ-035 WORDS=2, Miss_Addr=0x0000_004C, MM_Ready=1 always, MM_Data=addr-derived -> MM_Addr 0x48 then 0x4C, Refill_Addr=0x48, Refill_Data={data@0x4C,data@0x48}, Refill_Valid 3 cycles after miss edge, CNT_REFILL=1.
REQ-036 MM_Ready low 3 cycles per word -> MM_Req/MM_Addr held stable across stall, Refill_Valid one pulse, data correct.
REQ-037 Abort pulsed after word 0 returned -> no Refill_Valid, CNT_ABORT=1, Busy low next cycle, new miss 0x100 then refills 0x100 correctly.
REQ-038 WORDS=4, Miss_Addr=0x0000_0038 -> MM_Addr 0x30,0x34,0x38,0x3C; Refill_Addr=0x30.
REQ-039 RESET low mid-FETCH -> all outputs zero next cycle; no stale Refill_Valid after release.
REQ-040 Force CNT_REFILL to 0xFFFFE, complete 3 refills -> reads 0xFFFFF, no wrap.
